// File: rtl/path_writer.sv
// path_writer: turns a stream of direction codes into the path memory image
// (moves at 0..len-1, length word at 2^memwidth-1). Optional psum via PATH_SUM_EN.
// Ports: clk, rst (sync, active-high), start, in_valid/in_dir/in_last/in_ready
// stream; en/we/addr/wdata memory write; fin, len, pos, err, full status;
// psum (only with PATH_SUM_EN) running edge-delta sum mod 2^datawidth.
module path_writer #(
  parameter int datawidth = 5,
  parameter int memwidth  = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 in_valid,
  input  logic [datawidth-1:0] in_dir,
  input  logic                 in_last,
  output logic                 in_ready,
  output logic                 en,
  output logic                 we,
  output logic [memwidth-1:0]  addr,
  output logic [datawidth-1:0] wdata,
  output logic                 fin,
  output logic [memwidth-1:0]  len,
  output logic [3:0]           pos,
  output logic                 err,
  output logic                 full
`ifdef PATH_SUM_EN
  ,
  output logic [datawidth-1:0] psum
`endif
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_COLLECT = 2'd1;
  localparam logic [1:0] S_LEN     = 2'd2;
  localparam logic [1:0] S_DONE    = 2'd3;

  localparam logic [memwidth-1:0] LEN_ADDR = '1;

  localparam logic [datawidth-1:0] D_RIGHT = datawidth'(1);
  localparam logic [datawidth-1:0] D_UP    = datawidth'(2);
  localparam logic [datawidth-1:0] D_LEFT  = datawidth'(3);
  localparam logic [datawidth-1:0] D_DOWN  = datawidth'(4);

  logic [1:0]           state_q, state_d;
  logic [memwidth-1:0]  cnt_q, cnt_d, cnt_inc;
  logic [3:0]           pos_q, pos_d;
  logic                 err_q, err_d;
  logic                 full_q, full_d;
  logic                 we_q, we_d;
  logic [memwidth-1:0]  addr_q, addr_d;
  logic [datawidth-1:0] wdata_q, wdata_d;
  logic                 fin_q, fin_d;
  logic [memwidth-1:0]  len_q, len_d;

  logic       mv_ok;
  logic [3:0] mv_tgt;
  logic       on_l, on_r;

  // Left/right grid columns; row limits are simple range checks.
  assign on_l = (pos_q == 4'd1) || (pos_q == 4'd4) || (pos_q == 4'd7);
  assign on_r = (pos_q == 4'd3) || (pos_q == 4'd6) || (pos_q == 4'd9);

  always_comb begin
    mv_ok  = 1'b0;
    mv_tgt = pos_q;
    unique case (1'b1)
      in_dir == D_RIGHT: begin
        mv_ok  = !on_r;
        mv_tgt = pos_q + 4'd1;
      end
      in_dir == D_UP: begin
        mv_ok  = pos_q > 4'd3;
        mv_tgt = pos_q - 4'd3;
      end
      in_dir == D_LEFT: begin
        mv_ok  = !on_l;
        mv_tgt = pos_q - 4'd1;
      end
      in_dir == D_DOWN: begin
        mv_ok  = pos_q < 4'd7;
        mv_tgt = pos_q + 4'd3;
      end
      default: ;
    endcase
  end

  assign cnt_inc = cnt_q + 1'b1;

`ifdef PATH_SUM_EN
  logic [datawidth-1:0] psum_q, psum_d;

  // Per-edge weights shared with the reader; unlisted edges weigh 0.
  function automatic logic [datawidth-1:0] edge_delta(
    input logic [3:0] f,
    input logic [3:0] t
  );
    int d;
    d = 0;
    case ({f, t})
      8'h52, 8'h54, 8'h12, 8'h14, 8'h32, 8'h74: d = -1;
      8'h56, 8'h58, 8'h36, 8'h78, 8'h96, 8'h98: d = 1;
      8'h23, 8'h47, 8'h63, 8'h87:               d = 2;
      8'h21, 8'h41, 8'h69, 8'h89:               d = -2;
      default:                                  d = 0;
    endcase
    return datawidth'(d);
  endfunction
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pos_d   = pos_q;
    err_d   = err_q;
    full_d  = full_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    fin_d   = 1'b0;
    len_d   = len_q;
`ifdef PATH_SUM_EN
    psum_d  = psum_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          cnt_d   = '0;
          pos_d   = 4'd5;
          err_d   = 1'b0;
          full_d  = 1'b0;
`ifdef PATH_SUM_EN
          psum_d  = '0;
`endif
          state_d = S_COLLECT;
        end
      end
      S_COLLECT: begin
        if (in_valid) begin
          if (mv_ok) begin
            we_d    = 1'b1;
            addr_d  = cnt_q;
            wdata_d = in_dir;
            cnt_d   = cnt_inc;
            pos_d   = mv_tgt;
`ifdef PATH_SUM_EN
            psum_d  = psum_q + edge_delta(pos_q, mv_tgt);
`endif
          end else begin
            err_d = 1'b1;
          end
          if (in_last) begin
            state_d = S_LEN;
          end else if (mv_ok && cnt_inc == LEN_ADDR) begin
            full_d  = 1'b1;
            state_d = S_LEN;
          end
        end
      end
      S_LEN: begin
        we_d    = 1'b1;
        addr_d  = LEN_ADDR;
        wdata_d = datawidth'(cnt_q);
        len_d   = cnt_q;
        state_d = S_DONE;
      end
      default: begin
        fin_d   = 1'b1;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      pos_q   <= 4'd5;
      err_q   <= 1'b0;
      full_q  <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      fin_q   <= 1'b0;
      len_q   <= '0;
`ifdef PATH_SUM_EN
      psum_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pos_q   <= pos_d;
      err_q   <= err_d;
      full_q  <= full_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      fin_q   <= fin_d;
      len_q   <= len_d;
`ifdef PATH_SUM_EN
      psum_q  <= psum_d;
`endif
    end
  end

  assign in_ready = (state_q == S_COLLECT);
  assign we       = we_q;
  assign en       = we_q;
  assign addr     = addr_q;
  assign wdata    = wdata_q;
  assign fin      = fin_q;
  assign len      = len_q;
  assign pos      = pos_q;
  assign err      = err_q;
  assign full     = full_q;
`ifdef PATH_SUM_EN
  assign psum     = psum_q;
`endif

endmodule
